// File: rtl/output_layer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_layer_ctrl_pkg
// Description : Shared sizes, FSM state encoding and sign-extension helpers
//               for the output-layer inference controller.
// Revision    : 1.0 - initial release
// ============================================================================
package output_layer_ctrl_pkg;

    localparam int N_OUT    = 10;
    localparam int N_HID    = 30;
    localparam int W_BITS   = 8;
    localparam int ACC_BITS = 22;
    localparam int P_BITS   = 2 * W_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widen a signed W_BITS value (e.g. a bias) to accumulator width.
    function automatic logic signed [ACC_BITS-1:0] sext_w(input logic signed [W_BITS-1:0] v);
        return {{(ACC_BITS-W_BITS){v[W_BITS-1]}}, v};
    endfunction

    // Widen a signed product to accumulator width.
    function automatic logic signed [ACC_BITS-1:0] sext_p(input logic signed [P_BITS-1:0] v);
        return {{(ACC_BITS-P_BITS){v[P_BITS-1]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_s8.sv
`default_nettype none
// ============================================================================
// Module      : mac_s8
// Description : Signed 8x8 multiply-accumulate with synchronous clear and
//               enable; clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_s8 #(
    parameter int ACC_BITS = 22
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [7:0]          a,
    input  logic signed [7:0]          b,
    output logic signed [ACC_BITS-1:0] acc
);

    logic signed [15:0] prod;
    assign prod = a * b;

    // Accumulate the sign-extended product; clear restarts a new dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_BITS-16){prod[15]}}, prod};
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : output_layer_ctrl
// Description : Sequential output layer of a small MLP. One MAC per cycle
//               computes each neuron's dot product, adds its bias, streams
//               the score out and tracks the argmax as the predicted digit.
// Revision    : 1.0 - initial release
// ============================================================================
module output_layer_ctrl #(
    parameter int N_OUT    = output_layer_ctrl_pkg::N_OUT,
    parameter int N_HID    = output_layer_ctrl_pkg::N_HID,
    parameter int W_BITS   = output_layer_ctrl_pkg::W_BITS,
    parameter int ACC_BITS = output_layer_ctrl_pkg::ACC_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [W_BITS*N_HID-1:0]       act_in,
    input  logic [W_BITS*N_OUT*N_HID-1:0] weights_HL,
    input  logic [W_BITS*N_OUT-1:0]       biases_HL,
    output logic                          busy,
    output logic                          result_valid,
    output logic [3:0]                    result_idx,
    output logic signed [ACC_BITS-1:0]    result_score,
    output logic                          done,
    output logic [3:0]                    digit
);

    import output_layer_ctrl_pkg::*;

    localparam int J_BITS = $clog2(N_HID);

    state_t                      state;
    logic [3:0]                  idx_i;
    logic [J_BITS-1:0]           idx_j;
    logic [W_BITS*N_HID-1:0]     act_q;
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [ACC_BITS-1:0]  max_score;
    logic [3:0]                  max_idx;

    // Unpacked views of the flat buses so the datapath can index by (i,j).
    logic signed [W_BITS-1:0] w_arr [N_OUT][N_HID];
    logic signed [W_BITS-1:0] b_arr [N_OUT];
    logic signed [W_BITS-1:0] a_arr [N_HID];

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_row
        assign b_arr[gi] = biases_HL[gi*W_BITS +: W_BITS];
        for (genvar gj = 0; gj < N_HID; gj++) begin : g_col
            assign w_arr[gi][gj] = weights_HL[(gi*N_HID+gj)*W_BITS +: W_BITS];
        end
    end

    for (genvar gj = 0; gj < N_HID; gj++) begin : g_act
        assign a_arr[gj] = act_q[gj*W_BITS +: W_BITS];
    end

    logic signed [W_BITS-1:0]   w_cur;
    logic signed [W_BITS-1:0]   a_cur;
    logic signed [ACC_BITS-1:0] score_cur;
    logic                       mac_clr;
    logic                       mac_en;

    assign w_cur     = w_arr[idx_i][idx_j];
    assign a_cur     = a_arr[idx_j];
    assign score_cur = acc + sext_w(b_arr[idx_i]);
    assign mac_clr   = ((state == IDLE) && start) || (state == FIN);
    assign mac_en    = (state == MAC);

    mac_s8 #(
        .ACC_BITS (ACC_BITS)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (w_cur),
        .b     (a_cur),
        .acc   (acc)
    );

    // Sequencing FSM with registered outputs and running argmax.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx_i        <= '0;
            idx_j        <= '0;
            act_q        <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_score <= '0;
            done         <= 1'b0;
            digit        <= '0;
            max_score    <= '0;
            max_idx      <= '0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        act_q <= act_in;
                        idx_i <= '0;
                        idx_j <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (idx_j == J_BITS'(N_HID-1)) begin
                        state <= FIN;
                    end else begin
                        idx_j <= idx_j + 1'b1;
                    end
                end
                FIN: begin
                    result_score <= score_cur;
                    result_idx   <= idx_i;
                    result_valid <= 1'b1;
                    idx_j        <= '0;
                    // Strict compare: ties keep the lower neuron index.
                    if ((idx_i == 4'd0) || (score_cur > max_score)) begin
                        max_score <= score_cur;
                        max_idx   <= idx_i;
                    end
                    if (idx_i == 4'(N_OUT-1)) begin
                        state <= DONE;
                    end else begin
                        idx_i <= idx_i + 1'b1;
                        state <= MAC;
                    end
                end
                DONE: begin
                    digit <= max_idx;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_layer_ctrl
// Description : Directed self-checking bench for output_layer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_layer_ctrl;

    localparam int N_OUT    = 10;
    localparam int N_HID    = 30;
    localparam int W_BITS   = 8;
    localparam int ACC_BITS = 22;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic [W_BITS*N_HID-1:0]       act_in = '0;
    logic [W_BITS*N_OUT*N_HID-1:0] weights_HL = '0;
    logic [W_BITS*N_OUT-1:0]       biases_HL = '0;
    logic                          busy;
    logic                          result_valid;
    logic [3:0]                    result_idx;
    logic signed [ACC_BITS-1:0]    result_score;
    logic                          done;
    logic [3:0]                    digit;

    int tests_run = 0;
    int tests_failed = 0;

    logic signed [ACC_BITS-1:0] res_score [N_OUT];
    int res_edge [N_OUT];
    int valid_cnt;
    int done_cnt;
    int done_edge;

    output_layer_ctrl #(
        .N_OUT    (N_OUT),
        .N_HID    (N_HID),
        .W_BITS   (W_BITS),
        .ACC_BITS (ACC_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .act_in       (act_in),
        .weights_HL   (weights_HL),
        .biases_HL    (biases_HL),
        .busy         (busy),
        .result_valid (result_valid),
        .result_idx   (result_idx),
        .result_score (result_score),
        .done         (done),
        .digit        (digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic fill_uniform(input logic [7:0] a, input logic [7:0] w, input logic [7:0] b);
        for (int j = 0; j < N_HID; j++) act_in[j*8 +: 8] = a;
        for (int k = 0; k < N_OUT*N_HID; k++) weights_HL[k*8 +: 8] = w;
        for (int i = 0; i < N_OUT; i++) biases_HL[i*8 +: 8] = b;
    endtask

    // Pulse start, then observe 340 edges (edge 0 = acceptance edge).
    // perturb: change act_in at edge 10 and re-pulse start at edges 50/200.
    // abort_at > 0: assert reset shortly after that edge and return.
    task automatic run(input bit perturb, input int abort_at);
        valid_cnt = 0;
        done_cnt  = 0;
        done_edge = -1;
        for (int i = 0; i < N_OUT; i++) begin
            res_score[i] = 22'sh15555;
            res_edge[i]  = -1;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int rel = 1; rel <= 340; rel++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                if (valid_cnt < N_OUT) begin
                    res_score[result_idx] = result_score;
                    res_edge[result_idx]  = rel;
                end
                valid_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_edge = rel;
            end
            #1;
            if (perturb) begin
                if (rel == 10) act_in = {N_HID{8'd7}};
                start = (rel == 50) || (rel == 200);
            end
            if (rel == abort_at) begin
                rst_n = 1'b0;
                #1;
                return;
            end
        end
    endtask

    task automatic check_run(input string pfx, input int exp_digit);
        check({pfx, "_valid_cnt"}, valid_cnt, N_OUT);
        check({pfx, "_done_cnt"}, done_cnt, 1);
        check({pfx, "_done_edge"}, done_edge, 311);
        check({pfx, "_digit"}, digit, exp_digit);
        check({pfx, "_busy_after"}, busy, 0);
        for (int i = 0; i < N_OUT; i++)
            check($sformatf("%s_edge%0d", pfx, i), res_edge[i], 31*(i+1));
    endtask

    initial begin
        // Reset state
        fill_uniform(8'd1, 8'd1, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_done", done, 0);
        check("rst_idx", result_idx, 0);
        check("rst_score", result_score, 0);
        check("rst_digit", digit, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: ones, bias(i)=i -> 30+i, digit 9
        fill_uniform(8'd1, 8'd1, 8'd0);
        for (int i = 0; i < N_OUT; i++) biases_HL[i*8 +: 8] = 8'(i);
        run(1'b0, 0);
        check_run("t1", 9);
        for (int i = 0; i < N_OUT; i++)
            check($sformatf("t1_score%0d", i), res_score[i], 30 + i);

        // T2: row 3 weights=2, act=5 -> score3=300, digit 3
        fill_uniform(8'd5, 8'd0, 8'd0);
        for (int j = 0; j < N_HID; j++) weights_HL[(3*N_HID+j)*8 +: 8] = 8'd2;
        run(1'b0, 0);
        check_run("t2", 3);
        for (int i = 0; i < N_OUT; i++)
            check($sformatf("t2_score%0d", i), res_score[i], (i == 3) ? 300 : 0);

        // T3: reset at edge 100 of a T2-pattern run
        run(1'b0, 100);
        check("t3_busy", busy, 0);
        check("t3_valid", result_valid, 0);
        check("t3_done", done, 0);
        check("t3_idx", result_idx, 0);
        check("t3_score", result_score, 0);
        check("t3_digit", digit, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("t3_no_done", done_cnt, 0);
        check("t3_valids_before", valid_cnt, 3);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 0);
        check_run("t3r", 3);
        for (int i = 0; i < N_OUT; i++)
            check($sformatf("t3r_score%0d", i), res_score[i], (i == 3) ? 300 : 0);

        // T4: extremes -128 -> 30*16384-128 = 491392 everywhere, tie -> digit 0
        fill_uniform(8'h80, 8'h80, 8'h80);
        run(1'b0, 0);
        check_run("t4", 0);
        for (int i = 0; i < N_OUT; i++)
            check($sformatf("t4_score%0d", i), res_score[i], 491392);

        // T5: act=2, w=1, bias=0 -> 60; later act_in change and start pulses ignored
        fill_uniform(8'd2, 8'd1, 8'd0);
        for (int i = 0; i < 4; i++) weights_HL[(6*N_HID+i)*8 +: 8] = 8'd3;
        run(1'b1, 0);
        check_run("t5", 6);
        for (int i = 0; i < N_OUT; i++)
            check($sformatf("t5_score%0d", i), res_score[i], (i == 6) ? 76 : 60);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
